// File: rtl/interrupt_trap_sequencer.sv
// Machine-mode interrupt entry/return sequencer: synchronises and masks IRQ lines, drains the pipeline,
// strobes mepc capture, redirects fetch to the trap vector and back on mret. Optional: IRQ_CAUSE_REG_EN adds mcause_out.
module interrupt_trap_sequencer #(
  parameter logic [63:0] TRAP_VECTOR = 64'h100,
  parameter int          NUM_IRQ     = 3,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_IRQ-1:0] irq_lines_in,
  input  logic [NUM_IRQ-1:0] mie_in,
  input  logic               pipeline_busy_in,
  input  logic               mret_in,
  input  logic [63:0]        instr_address_in,
  input  logic [63:0]        csr_mepc_in,
  output logic               stall_out,
  output logic               flush_out,
  output logic               interrupt_signal_out,
  output logic               redirect_valid_out,
  output logic [63:0]        redirect_pc_out,
  output logic [NUM_IRQ-1:0] irq_ack_out,
  output logic               in_handler_out,
`ifdef IRQ_CAUSE_REG_EN
  output logic [63:0]        mcause_out,
`endif
  output logic [2:0]         state_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    ENTER   = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [2:0] id_q, id_d;
  logic [2:0] sel_id;
  logic       found;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] pending;
  logic [7:0]         pending_ext;

  logic               stall_d, flush_d, intr_d, rv_d, inh_d;
  logic [63:0]        pc_d;
  logic [NUM_IRQ-1:0] ack_d;

  // mepc itself is captured by the CSR block on the strobe; the address only passes by this block.
  logic unused_addr;
  assign unused_addr = ^instr_address_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_lines_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pending     = sync_q[SYNC_STAGES-1] & mie_in;
  assign pending_ext = 8'(pending);

  // Fixed priority: descending scan so the lowest set index is the last assignment.
  always_comb begin
    sel_id = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = 3'(i);
    end
    found = |pending;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // redirect_valid_out is a single-cycle qualifier for redirect_pc_out with no back-pressure;
  // the PC mux must accept it in the cycle it is high. The pc bus is zero whenever valid is low.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    stall_d = 1'b0;
    flush_d = 1'b0;
    intr_d  = 1'b0;
    rv_d    = 1'b0;
    inh_d   = 1'b0;
    pc_d    = 64'd0;
    ack_d   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = sel_id;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pending_ext[id_q])     state_d = IDLE;
        else if (!pipeline_busy_in) state_d = ENTER;
      end
      ENTER:   state_d = HANDLER;
      HANDLER: if (mret_in) state_d = RETURN;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    case (state_d)
      DRAIN: stall_d = 1'b1;
      ENTER: begin
        stall_d = 1'b1;
        flush_d = 1'b1;
        intr_d  = 1'b1;
        rv_d    = 1'b1;
        pc_d    = TRAP_VECTOR;
        for (int i = 0; i < NUM_IRQ; i++) ack_d[i] = (id_d == 3'(i));
      end
      HANDLER: inh_d = 1'b1;
      RETURN: begin
        flush_d = 1'b1;
        rv_d    = 1'b1;
        pc_d    = csr_mepc_in;
        inh_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_out            <= 1'b0;
      flush_out            <= 1'b0;
      interrupt_signal_out <= 1'b0;
      redirect_valid_out   <= 1'b0;
      redirect_pc_out      <= 64'd0;
      irq_ack_out          <= '0;
      in_handler_out       <= 1'b0;
    end else begin
      stall_out            <= stall_d;
      flush_out            <= flush_d;
      interrupt_signal_out <= intr_d;
      redirect_valid_out   <= rv_d;
      redirect_pc_out      <= pc_d;
      irq_ack_out          <= ack_d;
      in_handler_out       <= inh_d;
    end
  end

`ifdef IRQ_CAUSE_REG_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                mcause_out <= 64'd0;
    else if (state_d == ENTER) mcause_out <= {1'b1, 60'd0, id_d};
  end
`endif

  assign state_out = state_q;

endmodule

// File: tb/tb_interrupt_trap_sequencer.sv
// Directed bench for interrupt_trap_sequencer: expected redirects are queued by the stimulus and
// checked by an independent monitor; a small CSR model captures mepc on the strobe.
module tb_interrupt_trap_sequencer;

  localparam int NI = 3;
  localparam int W  = 64 + NI + 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [NI-1:0] irq_lines_in, mie_in;
  logic          pipeline_busy_in, mret_in;
  logic [63:0]   instr_address_in, csr_mepc_in;
  logic          stall_out, flush_out, interrupt_signal_out, redirect_valid_out, in_handler_out;
  logic [63:0]   redirect_pc_out;
  logic [NI-1:0] irq_ack_out;
  logic [2:0]    state_out;
`ifdef IRQ_CAUSE_REG_EN
  logic [63:0]   mcause_out;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got, mon_exp;
  int checks = 0;
  int errors = 0;
  int lat;
  logic flag_a, flag_b;

  interrupt_trap_sequencer #(.TRAP_VECTOR(64'h100), .NUM_IRQ(NI), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .irq_lines_in(irq_lines_in), .mie_in(mie_in),
    .pipeline_busy_in(pipeline_busy_in), .mret_in(mret_in), .instr_address_in(instr_address_in),
    .csr_mepc_in(csr_mepc_in), .stall_out(stall_out), .flush_out(flush_out),
    .interrupt_signal_out(interrupt_signal_out), .redirect_valid_out(redirect_valid_out),
    .redirect_pc_out(redirect_pc_out), .irq_ack_out(irq_ack_out), .in_handler_out(in_handler_out),
`ifdef IRQ_CAUSE_REG_EN
    .mcause_out(mcause_out),
`endif
    .state_out(state_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CSR model: mepc captured on the negedge while the strobe is high.
  always @(negedge clk_in or posedge rst_in) begin
    if (rst_in)                    csr_mepc_in <= 64'd0;
    else if (interrupt_signal_out) csr_mepc_in <= instr_address_in;
  end

  function automatic logic [W-1:0] pack(input logic [63:0] pc, input logic [NI-1:0] ack,
                                        input logic intr, input logic flush, input logic stall,
                                        input logic inh);
    return {pc, ack, intr, flush, stall, inh};
  endfunction

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (!rst_in && redirect_valid_out) begin
      mon_got = pack(redirect_pc_out, irq_ack_out, interrupt_signal_out, flush_out, stall_out,
                     in_handler_out);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected got=%h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL redirect got=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // Driver / checker tasks
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // which: 0 = stall_out high, 1 = in_handler_out high
  task automatic wait_cond(input int which, input string name);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_in);
      if ((which == 0 && stall_out) || (which == 1 && in_handler_out)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=0 exp=1", name);
    end
  endtask

  task automatic do_mret(input logic [63:0] pc);
    exp_q.push_back(pack(pc, '0, 1'b0, 1'b1, 1'b0, 1'b1));
    mret_in = 1'b1;
    @(negedge clk_in);
    mret_in = 1'b0;
  endtask

  task automatic take_irq(input logic [NI-1:0] irq, input logic [NI-1:0] mie,
                          input logic [NI-1:0] ack, input string name);
    exp_q.push_back(pack(64'h100, ack, 1'b1, 1'b1, 1'b1, 1'b0));
    mie_in = mie;
    irq_lines_in = irq;
    wait_cond(1, name);
    irq_lines_in = '0;
  endtask

  initial begin
    rst_in = 1'b1;
    irq_lines_in = '0;
    mie_in = '0;
    pipeline_busy_in = 1'b0;
    mret_in = 1'b0;
    instr_address_in = 64'd0;
    repeat (3) @(negedge clk_in);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_flush", 64'(flush_out), 64'd0);
    check("rst_intr", 64'(interrupt_signal_out), 64'd0);
    check("rst_rv", 64'(redirect_valid_out), 64'd0);
    check("rst_pc", redirect_pc_out, 64'd0);
    check("rst_ack", 64'(irq_ack_out), 64'd0);
    check("rst_inh", 64'(in_handler_out), 64'd0);
    check("rst_state", 64'(state_out), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Reset in the middle of DRAIN
    mie_in = 3'b001; irq_lines_in = 3'b001; pipeline_busy_in = 1'b1;
    wait_cond(0, "t1_drain");
    rst_in = 1'b1;
    @(negedge clk_in);
    check("t1_stall", 64'(stall_out), 64'd0);
    check("t1_rv", 64'(redirect_valid_out), 64'd0);
    check("t1_state", 64'(state_out), 64'd0);
    irq_lines_in = '0; mie_in = '0; pipeline_busy_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Basic entry: 2 sync cycles + DRAIN + ENTER after the raw edge
    instr_address_in = 64'h40;
    exp_q.push_back(pack(64'h100, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    mie_in = 3'b001; irq_lines_in = 3'b001;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_in);
      if (interrupt_signal_out) begin
        lat = c;
        break;
      end
    end
    check("t2_latency", 64'(lat), 64'd4);
    @(negedge clk_in);
    check("t2_handler", 64'(in_handler_out), 64'd1);
    check("t2_stall_released", 64'(stall_out), 64'd0);
    check("t2_mepc", csr_mepc_in, 64'h40);
    irq_lines_in = '0;

    // Return with a new request raised in the mret cycle
    mie_in = 3'b111; irq_lines_in = 3'b100;
    do_mret(64'h40);
    @(negedge clk_in);
    check("t5_idle_gap", 64'(state_out), 64'd0);
    instr_address_in = 64'h80;
    exp_q.push_back(pack(64'h100, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0));
    wait_cond(1, "t5_handler");
`ifdef IRQ_CAUSE_REG_EN
    check("t5_mcause", mcause_out, 64'h8000_0000_0000_0002);
`endif
    irq_lines_in = '0;
    do_mret(64'h80);
    repeat (2) @(negedge clk_in);

    // Drain wait: busy held for 5 cycles of DRAIN
    instr_address_in = 64'hC0;
    pipeline_busy_in = 1'b1;
    exp_q.push_back(pack(64'h100, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0));
    mie_in = 3'b010; irq_lines_in = 3'b010;
    wait_cond(0, "t3_drain");
    for (int k = 0; k < 5; k++) begin
      check("t3_stall", 64'(stall_out), 64'd1);
      check("t3_no_enter", 64'(interrupt_signal_out), 64'd0);
      @(negedge clk_in);
    end
    pipeline_busy_in = 1'b0;
    @(negedge clk_in);
    check("t3_enter", 64'(interrupt_signal_out), 64'd1);
    wait_cond(1, "t3_handler");
    irq_lines_in = '0;
    do_mret(64'hC0);
    repeat (2) @(negedge clk_in);

    // Priority and masking
    take_irq(3'b110, 3'b100, 3'b100, "t4_masked");
    do_mret(64'hC0);
    repeat (2) @(negedge clk_in);
    take_irq(3'b111, 3'b111, 3'b001, "t4_prio");
    do_mret(64'hC0);
    repeat (2) @(negedge clk_in);
    mie_in = 3'b000; irq_lines_in = 3'b111;
    flag_a = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (stall_out || state_out != 3'd0) flag_a = 1'b1;
    end
    check("t4_mie0_idle", 64'(flag_a), 64'd0);
    irq_lines_in = '0;
    repeat (2) @(negedge clk_in);

    // Abort: request drops during DRAIN
    mie_in = 3'b001; irq_lines_in = 3'b001; pipeline_busy_in = 1'b1;
    wait_cond(0, "t6_drain");
    irq_lines_in = '0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (|irq_ack_out || interrupt_signal_out) flag_a = 1'b1;
      if (!stall_out) flag_b = 1'b1;
    end
    check("t6_no_ack", 64'(flag_a), 64'd0);
    check("t6_released", 64'(flag_b), 64'd1);
    check("t6_state", 64'(state_out), 64'd0);
    pipeline_busy_in = 1'b0;
    repeat (3) @(negedge clk_in);

    check("redirects_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
